l1_lookup_arb: RTL and testbench

//  Two-requester scheduler in front of the L1 tag/LRU lookup pipeline (l1_lrum + tag SRAM).

---
 rtl/l1_lookup_arb_pkg.sv | 15 +
 rtl/l1_lookup_arb_rr_arb2.sv | 35 +++
 rtl/l1_lookup_arb.sv | 97 +++++++++
 tb/tb_l1_lookup_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_lookup_arb_pkg.sv
// Shared definitions for the L1 lookup scheduler: widths, FSM encoding and source IDs.
package l1_lookup_arb_pkg;

  localparam int CORE_IDX_WIDTH = 8;
  localparam int CORE_TAG_WIDTH = 20;

  typedef enum logic {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_t;

  localparam logic SRC_CORE = 1'b0;
  localparam logic SRC_FILL = 1'b1;

endpackage

// File: rtl/l1_lookup_arb_rr_arb2.sv
// Two-way round-robin arbiter; the preferred port flips to the loser after every grant.
module l1_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       rr
);

  logic rr_r;

  always_comb begin
    gnt = 2'b00;
    if (adv) begin
      if (&elig) begin
        gnt[rr_r] = 1'b1;
      end else begin
        gnt = elig;
      end
    end
  end

  // Next preference is the port that did not win: winner 0 -> 1, winner 1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r <= 1'b0;
    end else if (|gnt) begin
      rr_r <= gnt[0];
    end
  end

  assign rr = rr_r;

endmodule

// File: rtl/l1_lookup_arb.sv
// Two-requester scheduler in front of the L1 tag/LRU lookup pipe with miss-index blocking.
module l1_lookup_arb
  import l1_lookup_arb_pkg::*;
#(
  parameter int IDX_W = CORE_IDX_WIDTH,
  parameter int TAG_W = CORE_TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lru_ready,
  input  logic             stall,
  input  logic             miss_pend,
  input  logic [IDX_W-1:0] miss_idx,
  input  logic             r0_val,
  input  logic [IDX_W-1:0] r0_idx,
  input  logic [TAG_W-1:0] r0_tag,
  output logic             r0_rdy,
  input  logic             r1_val,
  input  logic [IDX_W-1:0] r1_idx,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             r1_rdy,
  output logic             lk_req,
  output logic [IDX_W-1:0] lk_idx,
  output logic             lk_val_r,
  output logic             lk_src_r,
  output logic [TAG_W-1:0] lk_tag_r,
  output arb_state_t       dbg_state,
  output logic             dbg_rr
);

  arb_state_t       state_q, state_d;
  logic [1:0]       elig;
  logic [1:0]       gnt;
  logic             adv;
  logic             val_q;
  logic             src_q;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_INIT: if (lru_ready)  state_d = ARB_RUN;
      ARB_RUN:  if (!lru_ready) state_d = ARB_INIT;
      default:  state_d = ARB_INIT;
    endcase
  end

  // Miss blocking uses this cycle's miss_pend/miss_idx so a just-raised miss already blocks.
  assign elig[0] = r0_val & ~(miss_pend & (r0_idx == miss_idx));
  assign elig[1] = r1_val & ~(miss_pend & (r1_idx == miss_idx));
  assign adv     = ~rst & (state_q == ARB_RUN) & ~stall;

  l1_rr_arb2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .elig (elig),
    .adv  (adv),
    .gnt  (gnt),
    .rr   (dbg_rr)
  );

  // Handshake: a request transfers in the cycle where ri_val & ri_rdy; the requester
  // holds val/idx/tag stable until then, and rdy is only raised for an eligible valid.
  assign r0_rdy = gnt[0];
  assign r1_rdy = gnt[1];
  assign lk_req = |gnt;
  assign lk_idx = rst ? '0 : (gnt[1] ? r1_idx : r0_idx);

  // The read stage has no hold, so stall never freezes the analyze-stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= 1'b0;
      src_q <= SRC_CORE;
      tag_q <= '0;
    end else begin
      val_q <= lk_req;
      if (lk_req) begin
        src_q <= gnt[1] ? SRC_FILL : SRC_CORE;
        tag_q <= gnt[1] ? r1_tag : r0_tag;
      end
    end
  end

  assign lk_val_r  = val_q & ~rst;
  assign lk_src_r  = src_q & ~rst;
  assign lk_tag_r  = rst ? '0 : tag_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_l1_lookup_arb.sv
// Bench for l1_lookup_arb: directed scenarios plus random traffic against a cycle-level model.
module tb_l1_lookup_arb;
  import l1_lookup_arb_pkg::*;

  localparam int IW = 8;
  localparam int TW = 20;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, lru_ready, stall, miss_pend;
  logic [IW-1:0] miss_idx, r0_idx, r1_idx, lk_idx;
  logic [TW-1:0] r0_tag, r1_tag, lk_tag_r;
  logic          r0_val, r1_val, r0_rdy, r1_rdy;
  logic          lk_req, lk_val_r, lk_src_r, dbg_rr;
  arb_state_t    dbg_state;

  l1_lookup_arb #(.IDX_W(IW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .lru_ready(lru_ready), .stall(stall),
    .miss_pend(miss_pend), .miss_idx(miss_idx),
    .r0_val(r0_val), .r0_idx(r0_idx), .r0_tag(r0_tag), .r0_rdy(r0_rdy),
    .r1_val(r1_val), .r1_idx(r1_idx), .r1_tag(r1_tag), .r1_rdy(r1_rdy),
    .lk_req(lk_req), .lk_idx(lk_idx), .lk_val_r(lk_val_r), .lk_src_r(lk_src_r),
    .lk_tag_r(lk_tag_r), .dbg_state(dbg_state), .dbg_rr(dbg_rr)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [IW:0] gnt_q[$];   // {src, idx} of each predicted grant
  logic [TW:0] ana_q[$];   // {src, tag} of each predicted analyze-stage entry

  // reference model state: running flag, preferred port, lookup in flight
  bit          m_run = 1'b0;
  bit          m_pref = 1'b0;
  bit          m_pend = 1'b0;
  logic [TW:0] m_pend_ent;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluates the model for the inputs now applied, then waits for the sampling edge.
  task automatic tick(output int g);
    bit e0, e1;
    e0 = r0_val && !(miss_pend && r0_idx == miss_idx);
    e1 = r1_val && !(miss_pend && r1_idx == miss_idx);
    g = -1;
    if (!rst && m_run && !stall) begin
      if (e0 && e1) g = int'(m_pref);
      else if (e0)  g = 0;
      else if (e1)  g = 1;
    end
    if (m_pend && !rst) ana_q.push_back(m_pend_ent);
    m_pend = (g >= 0);
    if (g == 0) begin
      gnt_q.push_back({1'b0, r0_idx});
      m_pend_ent = {1'b0, r0_tag};
    end else if (g == 1) begin
      gnt_q.push_back({1'b1, r1_idx});
      m_pend_ent = {1'b1, r1_tag};
    end
    if (rst) begin
      m_run = 1'b0;
      m_pref = 1'b0;
      m_pend = 1'b0;
    end else begin
      m_run = lru_ready;
      if (g >= 0) m_pref = (g == 0);
    end
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b1; r0_val = 1'b0; r1_val = 1'b0; stall = 1'b0; miss_pend = 1'b0;
    lru_ready = 1'b1;
    tick(g); nxt();
    rst = 1'b0;
    tick(g); nxt();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [IW:0] eg;
    logic [TW:0] ea;
    if (rst) begin
      check("rst_quiet", {27'd0, r0_rdy, r1_rdy, lk_req, lk_val_r, lk_src_r}, 32'd0);
      check("rst_tag", 32'(lk_tag_r), 32'd0);
    end else begin
      if ((r0_rdy && !r0_val) || (r1_rdy && !r1_val))
        check("rdy_without_val", {30'd0, r0_rdy, r1_rdy}, {30'd0, r0_val, r1_val});
      if (lk_req || r0_rdy || r1_rdy) begin
        if (gnt_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_grant: got r0_rdy=%0b r1_rdy=%0b expected none at %0t",
                   r0_rdy, r1_rdy, $time);
        end else begin
          eg = gnt_q.pop_front();
          check("grant_onehot", {29'd0, lk_req, r1_rdy, r0_rdy}, {29'd0, 1'b1, eg[IW], ~eg[IW]});
          check("lk_idx", 32'(lk_idx), 32'(eg[IW-1:0]));
        end
      end
      if (lk_val_r) begin
        if (ana_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_analyze: got lk_val_r=1 expected 0 at %0t", $time);
        end else begin
          ea = ana_q.pop_front();
          check("ana_src", 32'(lk_src_r), 32'(ea[TW]));
          check("ana_tag", 32'(lk_tag_r), 32'(ea[TW-1:0]));
        end
      end
    end
  end

  initial begin
    int g;
    rst = 1'b1; lru_ready = 1'b0; stall = 1'b0; miss_pend = 1'b0; miss_idx = '0;
    r0_val = 1'b0; r0_idx = '0; r0_tag = '0;
    r1_val = 1'b0; r1_idx = '0; r1_tag = '0;
    tick(g); nxt();

    // held in INIT until lru_ready is seen
    rst = 1'b0; r0_val = 1'b1; r0_idx = 8'h03; r0_tag = 20'h11111;
    for (int i = 0; i < 10; i++) begin
      tick(g);
      check("t1_no_grant_init", {30'd0, r0_rdy, lk_req}, 32'd0);
      nxt();
    end
    lru_ready = 1'b1;
    tick(g); check("t1_ready_edge", 32'(r0_rdy), 32'd0); nxt();
    tick(g);
    check("t1_run_rdy", 32'(r0_rdy), 32'd1);
    check("t1_state_run", 32'(dbg_state), 32'(ARB_RUN));
    nxt();
    r0_val = 1'b0;

    // alternation with both ports requesting
    do_reset();
    r0_val = 1'b1; r1_val = 1'b1; r0_idx = 8'h40; r1_idx = 8'h41;
    for (int k = 0; k < 4; k++) begin
      r0_tag = 20'(32'h100 + k); r1_tag = 20'(32'h200 + k);
      tick(g);
      check("t2_order", 32'(r1_rdy), 32'(k % 2));
      if (k > 0) check("t2_src_lag", {30'd0, lk_val_r, lk_src_r}, {30'd0, 1'b1, 1'(((k - 1) % 2))});
      nxt();
    end
    r0_val = 1'b0; r1_val = 1'b0;
    tick(g); check("t2_src_last", {30'd0, lk_val_r, lk_src_r}, 32'd3); nxt();

    // outstanding miss blocks the matching index only
    miss_pend = 1'b1; miss_idx = 8'h15;
    r0_val = 1'b1; r0_idx = 8'h15; r1_val = 1'b1; r1_idx = 8'h20;
    tick(g); check("t3_blocked", {30'd0, r1_rdy, r0_rdy}, 32'd2); nxt();
    r1_val = 1'b0; miss_pend = 1'b0;
    tick(g); check("t3_unblocked", 32'(r0_rdy), 32'd1); nxt();
    r0_val = 1'b0;

    // stall blocks new grants but the issued lookup still lands
    r1_val = 1'b1; r1_idx = 8'h33; r1_tag = 20'hABCDE;
    tick(g); check("t4_grant", 32'(r1_rdy), 32'd1); nxt();
    stall = 1'b1; r1_tag = 20'h12345; r0_val = 1'b1; r0_idx = 8'h34;
    tick(g);
    check("t4_ana_val", {30'd0, lk_val_r, lk_src_r}, 32'd3);
    check("t4_ana_tag", 32'(lk_tag_r), 32'hABCDE);
    check("t4_no_req", 32'(lk_req), 32'd0);
    nxt();
    for (int i = 0; i < 2; i++) begin
      tick(g); check("t4_stall_hold", {30'd0, lk_req, lk_val_r}, 32'd0); nxt();
    end
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(g); nxt();
      if (g == 0) r0_val = 1'b0;
      if (g == 1) r1_val = 1'b0;
    end

    // reset right after a grant drops the in-flight lookup
    r0_val = 1'b1; r0_idx = 8'h09; r1_val = 1'b0;
    tick(g); check("t5_grant", 32'(r0_rdy), 32'd1); nxt();
    r0_val = 1'b0; rst = 1'b1;
    tick(g); check("t5_drop", 32'(lk_val_r), 32'd0); nxt();
    rst = 1'b0; lru_ready = 1'b0; r0_val = 1'b1; r1_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(g);
      check("t5_state_init", 32'(dbg_state), 32'(ARB_INIT));
      check("t5_rr_zero", 32'(dbg_rr), 32'd0);
      check("t5_quiet", {29'd0, lk_val_r, r0_rdy, r1_rdy}, 32'd0);
      nxt();
    end
    lru_ready = 1'b1;
    tick(g); check("t5_ready_edge", {30'd0, r0_rdy, r1_rdy}, 32'd0); nxt();
    tick(g); check("t5_first_grant", {30'd0, r0_rdy, r1_rdy}, 32'd2); nxt();
    r0_val = 1'b0; r1_val = 1'b0;

    // single requester, same index back to back
    do_reset();
    r0_val = 1'b1; r0_idx = 8'h07;
    for (int k = 0; k < 3; k++) begin
      r0_tag = 20'(32'h700 + k);
      tick(g);
      check("t6_req", 32'(lk_req), 32'd1);
      check("t6_idx", 32'(lk_idx), 32'h07);
      check("t6_rr", 32'(dbg_rr), (k == 0) ? 32'd0 : 32'd1);
      nxt();
    end
    r0_val = 1'b0;
    tick(g); check("t6_rr_after", 32'(dbg_rr), 32'd1); nxt();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      lru_ready = ($urandom_range(0, 19) != 0);
      stall = ($urandom_range(0, 3) == 0);
      miss_pend = ($urandom_range(0, 2) == 0);
      miss_idx = IW'($urandom_range(0, 7));
      if (!r0_val && $urandom_range(0, 1) == 1) begin
        r0_val = 1'b1; r0_idx = IW'($urandom_range(0, 7)); r0_tag = TW'($urandom);
      end
      if (!r1_val && $urandom_range(0, 1) == 1) begin
        r1_val = 1'b1; r1_idx = IW'($urandom_range(0, 7)); r1_tag = TW'($urandom);
      end
      tick(g); nxt();
      if (g == 0) r0_val = 1'b0;
      if (g == 1) r1_val = 1'b0;
    end

    rst = 1'b0; r0_val = 1'b0; r1_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(g); nxt();
    end
    check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    check("ana_q_drained", 32'(ana_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
